uart_tx_cfg: RTL and testbench
==============================

// Module: uart_tx_cfg
// PURPOSE
//  Parametrised UART transmitter: configurable data width, parity and stop bits, with a
//  one-entry holding register for back-to-back frames. Uses the external baud_gen baud_tick
//  (1 clk pulse per bit period). Sits between the host/FIFO (valid/ready) and the tx pin.
// PARAMETERS
//  DATA_BITS    8  data bits per frame, legal 5..9, sent LSB first
//  PARITY_MODE  0  0 = none, 1 = even, 2 = odd; value 3 is illegal (elaboration $error)
//  STOP_BITS    1  stop bits per frame, legal 1 or 2
// PORTS
//  clk        in   1          system clock; all state on rising edge
//  rst        in   1          asynchronous, active-high reset
//  baud_tick  in   1          one-clk pulse per bit period, from baud_gen
//  start      in   1          write strobe; frame accepted when start && ready
//  data_in    in   DATA_BITS  frame payload, sampled on accept
//  ready      out  1          holding register empty; start honoured only when high
//  tx         out  1          serial line, idle high, registered output
//  busy       out  1          high while a frame is on the line or the holding register is full
//  done       out  1          one-clk pulse on the baud_tick that ends the last stop bit
// BEHAVIOUR
//  Reset: tx=1, busy=0, ready=1, done=0, state=IDLE, holding register cleared. Asserting rst
//   mid-frame aborts it; tx returns high asynchronously; no done pulse for the aborted frame.
//  Accept: start && ready latches data_in into hold, computes parity (even: XOR of data bits;
//   odd: inverted XOR); ready=0 and busy=1 from the next cycle. start with ready=0 is ignored.
//  States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
//   IDLE: tx=1. On baud_tick with hold full: move hold into shifter, hold empties (ready=1
//    next cycle), state=START, tx=0 from the next cycle.
//   START: on baud_tick -> DATA, tx=data[0], bit counter=0.
//   DATA: on each baud_tick shift; after DATA_BITS bit periods -> PARITY (if PARITY_MODE!=0)
//    else STOP. Bit counter is $clog2(DATA_BITS) wide, no wrap beyond DATA_BITS-1.
//   PARITY: tx=parity bit for one bit period, then STOP.
//   STOP: tx=1 for STOP_BITS bit periods. On the final baud_tick: done=1 for that cycle; if
//    hold full -> START directly (tx=0 next cycle, zero idle bits); else -> IDLE.
//  Timing: every line bit lasts exactly one baud_tick interval; state/tx change only on
//   baud_tick cycles. Accept-to-start-bit latency: 1 clk to hold, then up to one baud period
//   (waits for next baud_tick). Frame length = 1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS ticks.
//  Simultaneous: start and baud_tick in same cycle while IDLE and hold empty -> accept now;
//   frame starts on the following baud_tick. start accepted during the STOP tick that
//   empties nothing is legal (ready was high) and chains with no gap.
//  busy = (state!=IDLE) || hold full; deasserts the cycle after done when hold empty.
//  data_in changes after accept have no effect on the frame in flight or in hold.
// TESTING (bench drives baud_tick every 16 clks; checks sample tx mid-bit)
//  1. 8N1, send 8'hA5 -> tx = 0,1,0,1,0,0,1,0,1,1 (start,LSB..MSB,stop); one done pulse;
//     busy falls 1 clk after done; ready high throughout after hold loads shifter.
//  2. DATA_BITS=7, PARITY_MODE=1, send 7'h41 -> bits 0,1,0,0,0,0,0,1,0(parity),1; with
//     PARITY_MODE=2 same data -> parity bit 1.
//  3. Back-to-back: accept 8'h55, then 8'hAA as soon as ready -> second start bit directly
//     follows first stop bit (no idle period); two done pulses exactly 10 ticks apart.
//  4. Backpressure: with frame in flight and hold full, pulse start with 8'hFF -> ignored;
//     only the two accepted frames appear on tx; ready low until hold drains.
//  5. STOP_BITS=2, send 8'h00 -> tx low for 9 periods then high 2 periods before done.
//  6. Assert rst during DATA bit 3 -> tx=1, busy=0, ready=1 immediately; no done; next frame
//     after reset release transmits correctly.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..9 data bits, optional even/odd parity, 1 or 2 stop bits,
// with a one-entry holding register so frames can be chained back to back without idle bits.
module uart_tx_cfg #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(DATA_BITS);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_next;
  logic [DATA_BITS-1:0] hold, shifter;
  logic                 hold_full, hold_par, par_bit;
  logic [CW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic                 tx_next;
  logic                 accept, last_bit, last_stop, load, bypass;

  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    return (PARITY_MODE == 2) ? ~^d : ^d;
  endfunction

  assign accept    = start && !hold_full;
  assign last_bit  = (bit_cnt == CW'(DATA_BITS - 1));
  assign last_stop = (state == STOP) && (stop_cnt == 1'(STOP_BITS - 1));
  assign load      = baud_tick && hold_full && ((state == IDLE) || last_stop);
  // A write landing on the final stop tick goes straight to the shifter so the next frame has no gap.
  assign bypass    = baud_tick && last_stop && !hold_full && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tx    <= 1'b1;
    end else begin
      state <= state_next;
      tx    <= tx_next;
    end
  end

  always_comb begin
    state_next = state;
    if (baud_tick) begin
      case (state)
        IDLE:    if (hold_full) state_next = START;
        START:   state_next = DATA;
        DATA:    if (last_bit) state_next = (PARITY_MODE != 0) ? PARITY : STOP;
        PARITY:  state_next = STOP;
        STOP:    if (last_stop) state_next = (hold_full || start) ? START : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    tx_next = tx;
    if (baud_tick) begin
      case (state_next)
        IDLE:    tx_next = 1'b1;
        START:   tx_next = 1'b0;
        DATA:    tx_next = (state == START) ? shifter[0] : shifter[1];
        PARITY:  tx_next = par_bit;
        STOP:    tx_next = 1'b1;
        default: tx_next = 1'b1;
      endcase
    end
    done  = baud_tick && last_stop;
    busy  = (state != IDLE) || hold_full;
    ready = !hold_full;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
      hold_par  <= 1'b0;
      shifter   <= '0;
      par_bit   <= 1'b0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
    end else begin
      if (accept && !bypass) begin
        hold      <= data_in;
        hold_par  <= par_of(data_in);
        hold_full <= 1'b1;
      end
      if (load) begin
        shifter   <= hold;
        par_bit   <= hold_par;
        hold_full <= 1'b0;
      end else if (bypass) begin
        shifter <= data_in;
        par_bit <= par_of(data_in);
      end
      if (baud_tick) begin
        case (state)
          START: bit_cnt <= '0;
          DATA: begin
            shifter <= {1'b0, shifter[DATA_BITS-1:1]};
            if (!last_bit) bit_cnt <= bit_cnt + 1'b1;
          end
          default: ;
        endcase
      end
      if (state != STOP) stop_cnt <= 1'b0;
      else if (baud_tick) stop_cnt <= last_stop ? 1'b0 : 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: four parameterisations share clock, reset and baud tick;
// a monitor deserialises each tx line mid-bit and checks each frame against the queue on done.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic        baud_tick;
  logic        start_v [4];
  logic [8:0]  data_v  [4];
  logic        ready_v [4];
  logic        tx_v    [4];
  logic        busy_v  [4];
  logic        done_v  [4];

  int          total = 0;
  int          bad   = 0;
  int          phase;
  int          tick_no;
  logic [15:0] exp_q [4][$];
  int          frame_len [4] = '{10, 10, 10, 11};
  logic        in_frame [4];
  logic [15:0] got [4];
  int          nbits [4];
  int          last_done_tick [4];
  int          done_gap [4];

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .start(start_v[0]), .data_in(data_v[0][7:0]),
    .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  uart_tx_cfg #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)) u_7e1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .start(start_v[1]), .data_in(data_v[1][6:0]),
    .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  uart_tx_cfg #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) u_7o1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .start(start_v[2]), .data_in(data_v[2][6:0]),
    .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  uart_tx_cfg #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .start(start_v[3]), .data_in(data_v[3][7:0]),
    .ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One baud tick every 16 clocks, driven just after the rising edge.
  initial begin
    phase = 0;
    baud_tick = 1'b0;
    tick_no = 0;
    forever begin
      @(posedge clk);
      #1;
      phase = (phase == 15) ? 0 : phase + 1;
      baud_tick = (phase == 15);
      if (baud_tick) tick_no++;
    end
  end

  initial begin
    for (int g = 0; g < 4; g++) begin
      in_frame[g] = 1'b0;
      got[g] = '0;
      nbits[g] = 0;
      last_done_tick[g] = 0;
      done_gap[g] = 0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        if (rst) begin
          in_frame[g] = 1'b0;
          nbits[g] = 0;
          got[g] = '0;
        end else begin
          if (phase == 7) begin
            if (!in_frame[g]) begin
              if (tx_v[g] == 1'b0) begin
                in_frame[g] = 1'b1;
                got[g] = '0;
                nbits[g] = 1;
              end
            end else if (nbits[g] < 16) begin
              got[g][nbits[g]] = tx_v[g];
              nbits[g]++;
            end
          end
          if (done_v[g]) begin
            if (exp_q[g].size() == 0) begin
              check_output($sformatf("unexpected_done%0d", g), 16'd1, 16'd0);
            end else begin
              check_output($sformatf("frame%0d", g), got[g], exp_q[g].pop_front());
              check_output($sformatf("frame_len%0d", g), 16'(nbits[g]), 16'(frame_len[g]));
            end
            done_gap[g] = tick_no - last_done_tick[g];
            last_done_tick[g] = tick_no;
            in_frame[g] = 1'b0;
            nbits[g] = 0;
          end
        end
      end
    end
  end

  task automatic apply_stimulus(input int g, input logic [8:0] d, input logic [15:0] exp_frame,
                                input bit push);
    bit seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (ready_v[g]) seen = 1;
    end
    if (!seen) check_output("ready_timeout", 16'd0, 16'd1);
    @(posedge clk);
    #1;
    start_v[g] = 1'b1;
    data_v[g] = d;
    if (push) exp_q[g].push_back(exp_frame);
    @(posedge clk);
    #1;
    start_v[g] = 1'b0;
    data_v[g] = 9'h1FF;
  endtask

  task automatic wait_done(input int g);
    bit seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (done_v[g]) seen = 1;
    end
    if (!seen) check_output("done_timeout", 16'd0, 16'd1);
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 4; g++) begin
      start_v[g] = 1'b0;
      data_v[g] = '0;
    end
    repeat (3) @(negedge clk);
    check_output("rst_tx", 16'(tx_v[0]), 16'd1);
    check_output("rst_busy", 16'(busy_v[0]), 16'd0);
    check_output("rst_ready", 16'(ready_v[0]), 16'd1);
    check_output("rst_done", 16'(done_v[0]), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 8N1 0xA5: line bits 0,1,0,1,0,0,1,0,1,1
    apply_stimulus(0, 9'h0A5, 16'h034A, 1);
    @(negedge clk);
    check_output("t1_ready_low", 16'(ready_v[0]), 16'd0);
    check_output("t1_busy_high", 16'(busy_v[0]), 16'd1);
    wait_done(0);
    check_output("t1_ready_at_done", 16'(ready_v[0]), 16'd1);
    check_output("t1_busy_at_done", 16'(busy_v[0]), 16'd1);
    @(negedge clk);
    check_output("t1_busy_after_done", 16'(busy_v[0]), 16'd0);

    // 7E1 / 7O1 0x41: 0,1,0,0,0,0,0,1,p,1 with p=0 even, p=1 odd
    apply_stimulus(1, 9'h041, 16'h0282, 1);
    wait_done(1);
    apply_stimulus(2, 9'h041, 16'h0382, 1);
    wait_done(2);

    // Back-to-back 0x55 then 0xAA, with a 0xFF write that must be refused
    apply_stimulus(0, 9'h055, 16'h02AA, 1);
    apply_stimulus(0, 9'h0AA, 16'h0354, 1);
    @(negedge clk);
    check_output("t4_ready_low", 16'(ready_v[0]), 16'd0);
    @(posedge clk);
    #1;
    start_v[0] = 1'b1;
    data_v[0] = 9'h0FF;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    @(negedge clk);
    check_output("t4_ready_still_low", 16'(ready_v[0]), 16'd0);
    wait_done(0);
    check_output("t3_ready_at_first_done", 16'(ready_v[0]), 16'd0);
    @(negedge clk);
    check_output("t3_ready_after_drain", 16'(ready_v[0]), 16'd1);
    check_output("t3_busy_chained", 16'(busy_v[0]), 16'd1);
    wait_done(0);
    @(negedge clk);
    check_output("t3_done_gap", 16'(done_gap[0]), 16'd10);

    // 8N2 0x00: nine low bits then two stop bits
    apply_stimulus(3, 9'h000, 16'h0600, 1);
    wait_done(3);

    // Reset while data bit 3 (a zero) of 0xC3 is on the line
    apply_stimulus(0, 9'h0C3, 16'h0000, 0);
    begin
      bit seen = 0;
      for (int i = 0; i < 500 && !seen; i++) begin
        @(negedge clk);
        if (nbits[0] == 5) seen = 1;
      end
      if (!seen) check_output("bit3_timeout", 16'd0, 16'd1);
    end
    check_output("t6_tx_low_before", 16'(tx_v[0]), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_output("t6_tx", 16'(tx_v[0]), 16'd1);
    check_output("t6_busy", 16'(busy_v[0]), 16'd0);
    check_output("t6_ready", 16'(ready_v[0]), 16'd1);
    check_output("t6_done", 16'(done_v[0]), 16'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    apply_stimulus(0, 9'h03C, 16'h0278, 1);
    wait_done(0);

    repeat (12 * 16) @(negedge clk);
    for (int g = 0; g < 4; g++)
      check_output($sformatf("queue_empty%0d", g), 16'(exp_q[g].size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
